// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep controller.
package tt_pkg;

    localparam int NUM_CODES = 8;
    localparam int CODE_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/tt_eval.sv
// Combinational truth-table evaluator: f is 1 for codes 0, 4, 6 and 7.
module tt_eval
    import tt_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic              f
);

    // Decode the 3-bit code into the function output.
    always_comb begin
        f = 1'b0;
        case (code)
            3'd0, 3'd4, 3'd6, 3'd7: f = 1'b1;
            default:                f = 1'b0;
        endcase
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweep controller: applies codes 0..7 to the evaluator, holds each for
// DWELL cycles, captures the response mask and compares it with the
// expected mask latched at start.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep are held
// RUN   | stepping codes, sampling f on the last dwell cycle of each
// FIN   | one-cycle done pulse, mismatch valid; back to IDLE next
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        expect_i,
    output logic [CODE_W-1:0] code_o,
    output logic              f_o,
    output logic [7:0]        mask_o,
    output logic [3:0]        ones_o,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);

    localparam logic [7:0]        DWELL_LAST = 8'(DWELL - 1);
    localparam logic [CODE_W-1:0] CODE_LAST  = CODE_W'(NUM_CODES - 1);

    state_t              state_q, state_d;
    logic [7:0]          dwell_q, dwell_d;
    logic [7:0]          exp_q, exp_d;
    logic [CODE_W-1:0]   code_d;
    logic [7:0]          mask_d;
    logic [7:0]          mask_samp;
    logic [3:0]          ones_d;
    logic                busy_d, done_d, mism_d;

    tt_eval u_eval (
        .code (code_o),
        .f    (f_o)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        exp_d     = exp_q;
        code_d    = code_o;
        mask_d    = mask_o;
        ones_d    = ones_o;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        mism_d    = mismatch;
        mask_samp = mask_o;
        mask_samp[code_o] = f_o;

        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    // abort wins over start and clears held results
                    code_d = '0;
                    mask_d = '0;
                    ones_d = '0;
                    mism_d = 1'b0;
                end else if (start) begin
                    state_d = ST_RUN;
                    code_d  = '0;
                    dwell_d = '0;
                    mask_d  = '0;
                    ones_d  = '0;
                    exp_d   = expect_i;
                    mism_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    code_d  = '0;
                    dwell_d = '0;
                    mask_d  = '0;
                    ones_d  = '0;
                    mism_d  = 1'b0;
                end else if (dwell_q == DWELL_LAST) begin
                    mask_d = mask_samp;
                    ones_d = ones_o + {3'b000, f_o};
                    if (code_o == CODE_LAST) begin
                        // final sample: compare the complete mask on the way into FIN
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mism_d  = (mask_samp != exp_q);
                    end else begin
                        code_d  = code_o + 1'b1;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            exp_q    <= '0;
            code_o   <= '0;
            mask_o   <= '0;
            ones_o   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            exp_q    <= exp_d;
            code_o   <= code_d;
            mask_o   <= mask_d;
            ones_o   <= ones_d;
            busy     <= busy_d;
            done     <= done_d;
            mismatch <= mism_d;
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (DWELL=1 and DWELL=3) share the
// inputs; a sweep-timeline model predicts every output each cycle.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [7:0] expect_v;

    logic [2:0] code1, code3;
    logic       f1, f3, busy1, busy3, done1, done3, mism1, mism3;
    logic [7:0] mask1, mask3;
    logic [3:0] ones1, ones3;

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expect_i(expect_v),
        .code_o(code1), .f_o(f1), .mask_o(mask1), .ones_o(ones1),
        .busy(busy1), .done(done1), .mismatch(mism1)
    );

    tt_sweep_ctrl #(.DWELL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expect_i(expect_v),
        .code_o(code3), .f_o(f3), .mask_o(mask3), .ones_o(ones3),
        .busy(busy3), .done(done3), .mismatch(mism3)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Truth table from the function definition: codes 0,4,6,7 give 1.
    logic [7:0] tt_ref;

    // Model: a sweep is described by the number of edges k since accept.
    int         dw [2];
    bit         m_run [2];
    bit         m_fin [2];
    int         m_k [2];
    logic [7:0] m_exp [2];
    logic [7:0] m_mask [2];
    logic [3:0] m_ones [2];
    logic [2:0] m_code [2];
    bit         m_busy [2];
    bit         m_done [2];
    bit         m_mism [2];

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear(input int i);
        m_run[i] = 0; m_fin[i] = 0; m_k[i] = 0;
        m_mask[i] = '0; m_ones[i] = '0; m_code[i] = '0;
        m_busy[i] = 0; m_done[i] = 0; m_mism[i] = 0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                model_clear(i);
                m_exp[i] = '0;
            end else if (m_fin[i]) begin
                m_fin[i] = 0;
                m_done[i] = 0;
            end else if (m_run[i]) begin
                if (abort) begin
                    model_clear(i);
                end else begin
                    m_k[i]++;
                    m_code[i] = (m_k[i] / dw[i] > 7) ? 3'd7 : 3'(m_k[i] / dw[i]);
                    m_mask[i] = '0;
                    for (int c = 0; c < 8; c++)
                        if ((c + 1) * dw[i] <= m_k[i]) m_mask[i][c] = tt_ref[c];
                    m_ones[i] = 4'($countones(m_mask[i]));
                    if (m_k[i] == 8 * dw[i]) begin
                        m_run[i] = 0; m_fin[i] = 1; m_done[i] = 1; m_busy[i] = 0;
                        m_mism[i] = (m_mask[i] != m_exp[i]);
                    end
                end
            end else begin
                if (start && !abort) begin
                    model_clear(i);
                    m_run[i] = 1; m_busy[i] = 1; m_exp[i] = expect_v;
                end else if (abort) begin
                    m_code[i] = '0; m_mask[i] = '0; m_ones[i] = '0; m_mism[i] = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("d1_code", code1, m_code[0]);
        chk("d1_f",    f1,    tt_ref[m_code[0]]);
        chk("d1_mask", mask1, m_mask[0]);
        chk("d1_ones", ones1, m_ones[0]);
        chk("d1_busy", busy1, m_busy[0]);
        chk("d1_done", done1, m_done[0]);
        chk("d1_mism", mism1, m_mism[0]);
        chk("d3_code", code3, m_code[1]);
        chk("d3_f",    f3,    tt_ref[m_code[1]]);
        chk("d3_mask", mask3, m_mask[1]);
        chk("d3_ones", ones3, m_ones[1]);
        chk("d3_busy", busy3, m_busy[1]);
        chk("d3_done", done3, m_done[1]);
        chk("d3_mism", mism3, m_mism[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit         start;
        bit         abort;
        logic [7:0] expv;
        bit         busy;
        bit         done;
        int         code;
        int         mask;
        int         ones;
        bit         mism;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        int pulses;

        tt_ref = 8'h00;
        tt_ref[0] = 1'b1; tt_ref[4] = 1'b1; tt_ref[6] = 1'b1; tt_ref[7] = 1'b1;
        dw[0] = 1; dw[1] = 3;
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            m_exp[i] = '0;
        end

        // DWELL=1 sweep with expect D1; a re-pulsed start at record 4 is ignored
        tbl[0] = '{1, 0, 8'hD1, 1, 0, 0, 'h00, 0, 0};
        tbl[1] = '{0, 0, 8'hD1, 1, 0, 1, 'h01, 1, 0};
        tbl[2] = '{0, 0, 8'hD1, 1, 0, 2, 'h01, 1, 0};
        tbl[3] = '{0, 0, 8'hD1, 1, 0, 3, 'h01, 1, 0};
        tbl[4] = '{1, 0, 8'hD1, 1, 0, 4, 'h01, 1, 0};
        tbl[5] = '{0, 0, 8'hD1, 1, 0, 5, 'h11, 2, 0};
        tbl[6] = '{0, 0, 8'hD1, 1, 0, 6, 'h11, 2, 0};
        tbl[7] = '{0, 0, 8'hD1, 1, 0, 7, 'h51, 3, 0};
        tbl[8] = '{0, 0, 8'hD1, 0, 1, 7, 'hD1, 4, 0};
        tbl[9] = '{0, 0, 8'hD1, 0, 0, 7, 'hD1, 4, 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; expect_v = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_mask", mask1, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; abort = tbl[i].abort; expect_v = tbl[i].expv;
            tick();
            chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done1, tbl[i].done);
            chk($sformatf("tbl%0d_code", i), code1, tbl[i].code);
            chk($sformatf("tbl%0d_mask", i), mask1, tbl[i].mask);
            chk($sformatf("tbl%0d_ones", i), ones1, tbl[i].ones);
            chk($sformatf("tbl%0d_mism", i), mism1, tbl[i].mism);
        end
        start = 1'b0;
        repeat (20) tick();

        // DWELL=3, expect FF: done 24 cycles after accept, mismatch set
        expect_v = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 40 && !done3) begin
            tick();
            n++;
        end
        chk("d3_done_latency", n, 24);
        chk("d3_final_mask", mask3, 8'hD1);
        chk("d3_final_mism", mism3, 1);
        repeat (3) tick();

        // start and abort together in IDLE: not accepted
        start = 1'b1; abort = 1'b1;
        tick();
        chk("both_busy1", busy1, 0);
        chk("both_busy3", busy3, 0);
        start = 1'b0; abort = 1'b0;
        tick();

        // abort at code 4
        expect_v = 8'hD1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 20 && code1 != 3'd4) begin
            tick();
            n++;
        end
        chk("abort_reach_code4", code1, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_mask", mask1, 0);
        chk("abort_ones", ones1, 0);
        pulses = 0;
        repeat (12) begin
            tick();
            if (done1 || done3) pulses++;
        end
        chk("abort_no_done", pulses, 0);

        // reset at code 5, then a normal sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 20 && code1 != 3'd5) begin
            tick();
            n++;
        end
        chk("rst_reach_code5", code1, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_code", code1, 0);
        chk("midrst_mask", mask1, 0);
        chk("midrst_ones", ones1, 0);
        chk("midrst_busy", busy1, 0);
        pulses = 0;
        repeat (12) begin
            tick();
            if (done1 || done3) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        expect_v = 8'hD1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 20 && !done1) begin
            tick();
            n++;
        end
        chk("post_rst_latency", n, 8);
        chk("post_rst_mask", mask1, 8'hD1);
        chk("post_rst_ones", ones1, 4);
        chk("post_rst_mism", mism1, 0);
        repeat (20) tick();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 23) == 0);
            rst_n    = ($urandom_range(0, 79) != 0);
            expect_v = 8'($urandom);
            tick();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 1, meaning the number of cycles each input code is held before sampling (legal range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  in  1  request one full sweep of codes 0..7; single-cycle pulse or level.
REQ-005 SHALL have port abort  in  1  cancel a sweep in progress.
REQ-006 SHALL have port expect_i  in  8  expected response mask, bit k = expected f for code k.
REQ-007 SHALL have port code_o  out  3  code currently applied to the evaluator.
REQ-008 SHALL have port f_o  out  1  current evaluator output for code_o.
REQ-009 SHALL have port mask_o  out  8  captured responses, bit k = sampled f for code k.
REQ-010 SHALL have port ones_o  out  4  count of 1 responses captured, 0..8.
REQ-011 SHALL have port busy  out  1  high while a sweep is running.
REQ-012 SHALL have port done  out  1  one-cycle pulse when a sweep completes.
REQ-013 SHALL have port mismatch  out  1  mask_o != captured expect value; valid from done onward.

Function
REQ-014 SHALL implement states IDLE, RUN, FIN.
REQ-015 SHALL treat start as accepted in IDLE when start=1 and abort=0: code_o<=0, dwell count<=0, mask_o<=0, ones_o<=0, expect_i latched, mismatch<=0, next state RUN.
REQ-016 SHALL hold code_o constant for DWELL cycles in RUN; on the final dwell cycle it SHALL write f_o into mask_o[code_o] and add f_o to ones_o.
REQ-017 SHALL, after sampling with code_o<7, increment code_o and restart the dwell count; with code_o=7, it SHALL go to FIN and SHALL NOT wrap code_o.
REQ-018 SHALL in FIN assert done for exactly one cycle, drive mismatch from the latched expect value, and return to IDLE on the next edge.
REQ-019 SHALL make done high exactly 8*DWELL cycles after the start-accept edge.
REQ-020 SHALL make busy = 1 in RUN only; it SHALL be 0 in IDLE and FIN.
REQ-021 SHALL ignore start while in RUN or FIN; it SHALL NOT restart or extend the sweep.
REQ-022 SHALL on abort=1 in RUN go to IDLE next edge with no done pulse; mask_o, ones_o and mismatch SHALL be cleared to 0 and code_o set to 0.
REQ-023 SHALL give abort priority over start in IDLE (start not accepted) and ignore abort in FIN.
REQ-024 SHALL hold mask_o, ones_o and mismatch stable in IDLE after FIN until the next accepted start or abort.
REQ-025 SHALL compute f_o combinationally from code_o: f=1 for codes 0, 4, 6, 7 and f=0 for codes 1, 2, 3, 5.
REQ-026 SHALL size the dwell counter to 8 bits; ones_o SHALL never exceed 8.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, set state IDLE, code_o=0, mask_o=0, ones_o=0, busy=0, done=0, mismatch=0, and clear the dwell counter and latched expect value.
REQ-028 SHALL let reset mid-sweep override all other inputs; no done pulse SHALL follow it.

Structure
REQ-029 SHALL place the state enumeration, NUM_CODES=8 and CODE_W=3 in the shared package tt_pkg.
REQ-030 SHALL instantiate the combinational truth-table evaluator as a single sub-module, tt_eval (input 3-bit code, output f).
REQ-031 SHALL register every output except f_o.

Verification
REQ-032 SHALL cover: DWELL=1, start pulse, expect_i=8'hD1 -> done 8 cycles later, mask_o=8'hD1, ones_o=4, mismatch=0.
REQ-033 SHALL cover: DWELL=3, expect_i=8'hFF -> done 24 cycles after accept, mask_o=8'hD1, mismatch=1, code_o holds each value 3 cycles.
REQ-034 SHALL cover: abort asserted while code_o=4 -> IDLE next cycle, no done, mask_o=0, ones_o=0.
REQ-035 SHALL cover: start and abort high together in IDLE -> stays IDLE, busy=0; start re-pulsed mid-sweep -> done timing unchanged.
REQ-036 SHALL cover: rst_n=0 for one cycle at code_o=5 -> all outputs 0 next cycle, no done pulse; a following start sweeps normally.
